// File: rtl/irq_conditioner.sv
// N-channel input conditioner: sync, invert, debounce, rise detect, pending latch, masked irq.
// Latency in_async->stable = SYNC_STAGES+DEBOUNCE_CYCLES edges; rise_pulse/pending +1; irq +1 more.
module irq_conditioner #(
  parameter int CHANNELS        = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic [CHANNELS-1:0] in_async,
  input  logic [CHANNELS-1:0] invert,
  input  logic [CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0] mask,
  input  logic [CHANNELS-1:0] ack,
  output logic [CHANNELS-1:0] stable,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] pending,
  output logic                irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
  logic [CW-1:0]                        cnt_q [CHANNELS];
  logic [CHANNELS-1:0]                  cond;
  logic [CHANNELS-1:0]                  stable_d;
  logic [CHANNELS-1:0]                  rise_set;

  assign cond     = sync_q[SYNC_STAGES-1] ^ invert;
  assign rise_set = stable & ~stable_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= in_async;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Any sample matching stable restarts the count, so only an unbroken run flips it.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stable <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cond[i] == stable[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable[i] <= cond[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // In edge mode a new rise beats a coincident ack.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stable_d   <= '0;
      rise_pulse <= '0;
      pending    <= '0;
      irq        <= 1'b0;
    end else begin
      stable_d   <= stable;
      rise_pulse <= rise_set;
      pending    <= (edge_mode & ((pending & ~ack) | rise_set)) | (~edge_mode & stable);
      irq        <= |(pending & mask);
    end
  end

endmodule

// File: tb/tb_irq_conditioner.sv
// Directed plus randomized bench for irq_conditioner against a sample-history reference model.
module tb_irq_conditioner;

  localparam int CH = 8;
  localparam int S  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          nreset;
  logic [CH-1:0] in_async, invert, edge_mode, mask, ack;
  logic [CH-1:0] stable, rise_pulse, pending;
  logic          irq;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [CH-1:0] raw_h[$];
  logic [CH-1:0] cond_h[$];
  logic [CH-1:0] m_st, m_st_prev, m_rise, m_pend;
  logic          m_irq;

  irq_conditioner #(.CHANNELS(CH), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .nreset(nreset), .in_async(in_async), .invert(invert),
    .edge_mode(edge_mode), .mask(mask), .ack(ack), .stable(stable),
    .rise_pulse(rise_pulse), .pending(pending), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    raw_h.delete();
    cond_h.delete();
    m_st = '0; m_st_prev = '0; m_rise = '0; m_pend = '0; m_irq = 1'b0;
  endtask

  // A channel's stable level flips once the last D conditioned samples all disagree with it.
  task automatic model_edge();
    logic [CH-1:0] c, new_st, rset, new_pend;
    raw_h.push_back(in_async);
    if (raw_h.size() > S + 1) void'(raw_h.pop_front());
    c = (raw_h.size() > S) ? raw_h[raw_h.size()-1-S] : '0;
    c = c ^ invert;
    cond_h.push_back(c);
    if (cond_h.size() > D) void'(cond_h.pop_front());
    new_st = m_st;
    for (int i = 0; i < CH; i++) begin
      bit all_diff;
      all_diff = (cond_h.size() == D);
      foreach (cond_h[j]) if (cond_h[j][i] == m_st[i]) all_diff = 0;
      if (all_diff) new_st[i] = ~m_st[i];
    end
    rset = m_st & ~m_st_prev;
    for (int i = 0; i < CH; i++)
      new_pend[i] = edge_mode[i] ? (rset[i] | (m_pend[i] & ~ack[i])) : m_st[i];
    m_irq     = |(m_pend & mask);
    m_pend    = new_pend;
    m_rise    = rset;
    m_st_prev = m_st;
    m_st      = new_st;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("stable", 32'(stable), 32'(m_st));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    nreset = 1'b0; in_async = '0; invert = '0; edge_mode = '1; mask = '0; ack = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    steps(4);

    // reset asserted mid-count clears everything immediately
    in_async = 8'hFF;
    steps(4);
    @(negedge clk);
    nreset = 1'b0;
    #1;
    model_reset();
    chk("rst_stable", 32'(stable), 32'h0);
    chk("rst_rise", 32'(rise_pulse), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1 nreset = 1'b1;
    steps(5);
    chk("rel_stable_5", 32'(stable), 32'h00);
    step();
    chk("rel_stable_6", 32'(stable), 32'hFF);
    step();
    chk("rel_rise", 32'(rise_pulse), 32'hFF);
    chk("rel_pending", 32'(pending), 32'hFF);
    step();
    chk("rel_rise_off", 32'(rise_pulse), 32'h00);
    chk("rel_irq_masked", 32'(irq), 32'h0);
    ack = 8'hFF; step(); ack = '0;
    chk("ack_all", 32'(pending), 32'h00);
    in_async = '0;
    steps(8);

    // glitch shorter than the debounce window is rejected
    in_async[0] = 1'b1; steps(3); in_async[0] = 1'b0;
    steps(8);
    chk("glitch_stable0", 32'(stable[0]), 32'h0);
    chk("glitch_pend0", 32'(pending[0]), 32'h0);
    in_async[0] = 1'b1; steps(6);
    chk("held_stable0", 32'(stable[0]), 32'h1);
    in_async[0] = 1'b0; ack[0] = 1'b1; steps(8); ack[0] = 1'b0;

    // edge latch on ch2 with mask, ack, then ack coincident with a rise
    mask = 8'h04;
    in_async[2] = 1'b1; steps(7);
    chk("e_pend2", 32'(pending[2]), 32'h1);
    step();
    chk("e_irq", 32'(irq), 32'h1);
    ack[2] = 1'b1; step(); ack[2] = 1'b0;
    chk("e_ack_pend2", 32'(pending[2]), 32'h0);
    step();
    chk("e_ack_irq", 32'(irq), 32'h0);
    in_async[2] = 1'b0; steps(8);
    in_async[2] = 1'b1; steps(6);
    ack[2] = 1'b1; step(); ack[2] = 1'b0;
    chk("e_ack_vs_rise", 32'(pending[2]), 32'h1);
    ack[2] = 1'b1; step(); ack[2] = 1'b0;

    // level mode on ch5 ignores ack
    edge_mode[5] = 1'b0; in_async[5] = 1'b1; steps(7);
    chk("l_pend5", 32'(pending[5]), 32'h1);
    ack[5] = 1'b1; step(); ack[5] = 1'b0;
    chk("l_ack_pend5", 32'(pending[5]), 32'h1);
    in_async[5] = 1'b0; steps(S + D);
    chk("l_drop_early", 32'(pending[5]), 32'h1);
    step();
    chk("l_drop", 32'(pending[5]), 32'h0);

    // invert on a masked level channel, then unmask
    edge_mode[7] = 1'b0; mask = '0; invert[7] = 1'b1; steps(8);
    chk("inv_pend7", 32'(pending[7]), 32'h1);
    chk("inv_irq_off", 32'(irq), 32'h0);
    mask[7] = 1'b1; step();
    chk("inv_irq_on", 32'(irq), 32'h1);

    // randomized run, every cycle checked against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) in_async[$urandom_range(CH-1)] ^= 1'b1;
      if ($urandom_range(60) == 0) invert[$urandom_range(CH-1)] ^= 1'b1;
      if ($urandom_range(40) == 0) edge_mode[$urandom_range(CH-1)] ^= 1'b1;
      if ($urandom_range(20) == 0) mask[$urandom_range(CH-1)] ^= 1'b1;
      ack = ($urandom_range(3) == 0) ? CH'($urandom) : '0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
